// File: rtl/clock_period_meter.sv
// Purpose: measures period and high time of a slow square wave in core clock cycles.
// Latency: meas_valid/period/high_time update two clocks after sig_in is first sampled high.
// Backpressure: none; results are pulsed on meas_valid and held until the next update.
module clock_period_meter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 meas_valid,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Synchronizer and edge-detect delay flop.
    logic s1_q;
    logic s2_q;
    logic d_q;

    state_t               state_q,   state_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic [CNT_WIDTH-1:0] hi_lat_q,  hi_lat_d;
    logic [CNT_WIDTH-1:0] period_q,  period_d;
    logic [CNT_WIDTH-1:0] high_q,    high_d;
    logic                 valid_q,   valid_d;
    logic                 timeout_q, timeout_d;

    logic rise;
    logic fall;

    // Bring sig_in into the clk domain; runs independently of en so edges are
    // clean the moment measurement is enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            d_q  <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            d_q  <= s2_q;
        end
    end

    assign rise = s2_q & ~d_q;
    assign fall = ~s2_q & d_q;

    // State, counter and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_lat_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_lat_q  <= hi_lat_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: a rise closes the current period (and takes priority
    // over saturation), saturation without a rise flags timeout and re-arms.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_lat_d  = hi_lat_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    // First rise only starts the count.
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = hi_lat_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (fall) begin
                            hi_lat_d = cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Purpose: self-checking bench for clock_period_meter with a timestamp-based reference model.
// Latency: model predicts outputs edge by edge; outputs sampled 1ns after each rising edge.
// Backpressure: not applicable.
module tb_clock_period_meter;

    localparam int W    = 8;
    localparam int MAXC = (1 << W) - 1;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    clock_period_meter #(.CNT_WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: input samples taken at each edge, measurement expressed
    // as the edge index at which the current period started.
    int           m_e;
    logic         h1, h2, h3;   // sig_in sampled 1, 2, 3 edges ago
    int           m_mode;       // 0 idle, 1 waiting for first rise, 2 measuring
    int           t_start;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_per;
    logic [W-1:0] m_hio;
    logic         m_valid;
    logic         m_to;

    task automatic model_reset();
        m_e = 0; h1 = 0; h2 = 0; h3 = 0;
        m_mode = 0; t_start = 0; m_hi = '0;
        m_per = '0; m_hio = '0; m_valid = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic s, input logic e);
        logic r, f;
        int   age;
        r = h2 & ~h3;
        f = ~h2 & h3;
        m_valid = 1'b0;
        if (!e) begin
            m_mode = 0;
            m_to   = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (r) begin
                m_mode  = 2;
                t_start = m_e;
            end
        end else begin
            age = m_e - t_start;
            if (r) begin
                m_per   = W'(age);
                m_hio   = m_hi;
                m_valid = 1'b1;
                m_to    = 1'b0;
                t_start = m_e;
            end else if (age == MAXC) begin
                m_to   = 1'b1;
                m_mode = 1;
            end else if (f) begin
                m_hi = W'(age);
            end
        end
        h3 = h2; h2 = h1; h1 = s;
        m_e++;
    endtask

    task automatic step(input logic s, input logic e);
        sig_in = s;
        en     = e;
        @(posedge clk);
        model_edge(s, e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; sig_in = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({meas_valid, timeout, period, high_time} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b to=%b per=%0d hi=%0d expected all zero",
                     meas_valid, timeout, period, high_time);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step(1'b1, 1'b0);
        checks++;
        if ({meas_valid, timeout, period, high_time} !== 18'd0) begin
            errors++;
            $display("FAIL reset_disabled: got v=%b to=%b per=%0d hi=%0d expected all zero",
                     meas_valid, timeout, period, high_time);
        end
        idle(4);
    endtask

    task automatic test_div8();
        int nv = 0, nto = 0, first = -1;
        idle(4);
        for (int i = 0; i < 80; i++) begin
            step((i % 8) < 4, 1'b1);
            checks++;
            if ({meas_valid, timeout, period, high_time} !== {m_valid, m_to, m_per, m_hio}) begin
                errors++;
                $display("FAIL div8 cyc %0d: got v=%b to=%b per=%0d hi=%0d expected v=%b to=%b per=%0d hi=%0d",
                         i, meas_valid, timeout, period, high_time, m_valid, m_to, m_per, m_hio);
            end
            if (meas_valid && first < 0) first = i;
            nv  += int'(meas_valid);
            nto += int'(timeout);
        end
        checks++;
        if (first != 10 || nv != 9 || nto != 0 || period !== 8'd8 || high_time !== 8'd4) begin
            errors++;
            $display("FAIL div8_summary: got first=%0d pulses=%0d to_cycles=%0d per=%0d hi=%0d expected 10 9 0 8 4",
                     first, nv, nto, period, high_time);
        end
    endtask

    task automatic test_toggle();
        int nv = 0;
        idle(4);
        for (int i = 0; i < 40; i++) begin
            step((i % 2) == 0, 1'b1);
            checks++;
            if ({meas_valid, timeout, period, high_time} !== {m_valid, m_to, m_per, m_hio}) begin
                errors++;
                $display("FAIL toggle cyc %0d: got v=%b to=%b per=%0d hi=%0d expected v=%b to=%b per=%0d hi=%0d",
                         i, meas_valid, timeout, period, high_time, m_valid, m_to, m_per, m_hio);
            end
            nv += int'(meas_valid);
        end
        checks++;
        if (nv != 18 || period !== 8'd2 || high_time !== 8'd1) begin
            errors++;
            $display("FAIL toggle_summary: got pulses=%0d per=%0d hi=%0d expected 18 2 1", nv, period, high_time);
        end
    endtask

    task automatic test_asym();
        int nv = 0;
        idle(4);
        for (int i = 0; i < 60; i++) begin
            step((i % 10) < 3, 1'b1);
            checks++;
            if ({meas_valid, timeout, period, high_time} !== {m_valid, m_to, m_per, m_hio}) begin
                errors++;
                $display("FAIL asym cyc %0d: got v=%b to=%b per=%0d hi=%0d expected v=%b to=%b per=%0d hi=%0d",
                         i, meas_valid, timeout, period, high_time, m_valid, m_to, m_per, m_hio);
            end
            nv += int'(meas_valid);
        end
        checks++;
        if (nv != 5 || period !== 8'd10 || high_time !== 8'd3) begin
            errors++;
            $display("FAIL asym_summary: got pulses=%0d per=%0d hi=%0d expected 5 10 3", nv, period, high_time);
        end
    endtask

    task automatic test_timeout();
        int nv = 0;
        idle(4);
        for (int i = 0; i < 330; i++) begin
            step((i < 4) || (i >= 300 && i < 304) || (i >= 310 && i < 314), 1'b1);
            checks++;
            if ({meas_valid, timeout, period, high_time} !== {m_valid, m_to, m_per, m_hio}) begin
                errors++;
                $display("FAIL timeout cyc %0d: got v=%b to=%b per=%0d hi=%0d expected v=%b to=%b per=%0d hi=%0d",
                         i, meas_valid, timeout, period, high_time, m_valid, m_to, m_per, m_hio);
            end
            if (i == 256 || i == 257 || i == 311) begin
                checks++;
                if (timeout !== (i != 256)) begin
                    errors++;
                    $display("FAIL timeout_edge cyc %0d: got to=%b expected %b", i, timeout, i != 256);
                end
            end
            nv += int'(meas_valid);
        end
        checks++;
        if (nv != 1 || timeout !== 1'b0 || period !== 8'd10 || high_time !== 8'd4) begin
            errors++;
            $display("FAIL timeout_summary: got pulses=%0d to=%b per=%0d hi=%0d expected 1 0 10 4",
                     nv, timeout, period, high_time);
        end
    endtask

    task automatic test_boundary();
        int nv = 0, nto = 0;
        idle(4);
        for (int i = 0; i < 600; i++) begin
            step((i % 255) < 4, 1'b1);
            checks++;
            if ({meas_valid, timeout, period, high_time} !== {m_valid, m_to, m_per, m_hio}) begin
                errors++;
                $display("FAIL bound255 cyc %0d: got v=%b to=%b per=%0d hi=%0d expected v=%b to=%b per=%0d hi=%0d",
                         i, meas_valid, timeout, period, high_time, m_valid, m_to, m_per, m_hio);
            end
            nv  += int'(meas_valid);
            nto += int'(timeout);
        end
        checks++;
        if (nv != 2 || nto != 0 || period !== 8'd255) begin
            errors++;
            $display("FAIL bound255_summary: got pulses=%0d to_cycles=%0d per=%0d expected 2 0 255", nv, nto, period);
        end
        nv = 0;
        idle(4);
        for (int i = 0; i < 600; i++) begin
            step((i % 256) < 4, 1'b1);
            checks++;
            if ({meas_valid, timeout, period, high_time} !== {m_valid, m_to, m_per, m_hio}) begin
                errors++;
                $display("FAIL bound256 cyc %0d: got v=%b to=%b per=%0d hi=%0d expected v=%b to=%b per=%0d hi=%0d",
                         i, meas_valid, timeout, period, high_time, m_valid, m_to, m_per, m_hio);
            end
            nv += int'(meas_valid);
        end
        checks++;
        if (nv != 0 || timeout !== 1'b1 || period !== 8'd255) begin
            errors++;
            $display("FAIL bound256_summary: got pulses=%0d to=%b per=%0d expected 0 1 255", nv, timeout, period);
        end
    endtask

    task automatic test_en_drop();
        int bad = 0, first_after = -1;
        idle(4);
        for (int i = 0; i < 40; i++) begin
            step((i % 8) < 4, i != 20);
            checks++;
            if ({meas_valid, timeout, period, high_time} !== {m_valid, m_to, m_per, m_hio}) begin
                errors++;
                $display("FAIL en_drop cyc %0d: got v=%b to=%b per=%0d hi=%0d expected v=%b to=%b per=%0d hi=%0d",
                         i, meas_valid, timeout, period, high_time, m_valid, m_to, m_per, m_hio);
            end
            if (i >= 19 && i < 34 && (meas_valid || timeout || period !== 8'd8)) bad++;
            if (i >= 19 && meas_valid && first_after < 0) first_after = i;
        end
        checks++;
        if (bad != 0 || first_after != 34) begin
            errors++;
            $display("FAIL en_drop_summary: got bad_cycles=%0d first_valid=%0d expected 0 34", bad, first_after);
        end
    endtask

    task automatic test_async_reset();
        int nv = 0;
        idle(4);
        for (int i = 0; i < 30; i++) step((i % 8) < 4, 1'b1);
        sig_in = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({meas_valid, timeout, period, high_time} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b to=%b per=%0d hi=%0d expected all zero",
                     meas_valid, timeout, period, high_time);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step((i % 8) < 4, 1'b1);
            checks++;
            if ({meas_valid, timeout, period, high_time} !== {m_valid, m_to, m_per, m_hio}) begin
                errors++;
                $display("FAIL post_reset cyc %0d: got v=%b to=%b per=%0d hi=%0d expected v=%b to=%b per=%0d hi=%0d",
                         i, meas_valid, timeout, period, high_time, m_valid, m_to, m_per, m_hio);
            end
            nv += int'(meas_valid);
        end
        checks++;
        if (nv != 4 || period !== 8'd8 || high_time !== 8'd4) begin
            errors++;
            $display("FAIL post_reset_summary: got pulses=%0d per=%0d hi=%0d expected 4 8 4", nv, period, high_time);
        end
    endtask

    task automatic test_random();
        int hi, lo;
        logic e;
        idle(4);
        for (int seg = 0; seg < 20; seg++) begin
            hi = $urandom_range(1, 40);
            lo = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 40);
            for (int i = 0; i < hi + lo; i++) begin
                e = ($urandom_range(0, 199) != 0);
                step(i < hi, e);
                checks++;
                if ({meas_valid, timeout, period, high_time} !== {m_valid, m_to, m_per, m_hio}) begin
                    errors++;
                    $display("FAIL random seg %0d cyc %0d: got v=%b to=%b per=%0d hi=%0d expected v=%b to=%b per=%0d hi=%0d",
                             seg, i, meas_valid, timeout, period, high_time, m_valid, m_to, m_per, m_hio);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_div8();
        test_toggle();
        test_asym();
        test_timeout();
        test_boundary();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the frequency and duty cycle of a slow, divided or external square wave in units of the system clock. It is the receiving end of the clock-divider/counter family: a divided clock or counter MSB from the divider blocks drives `sig_in`, and the meter reports the cycles per period and cycles high. It is used for on-chip checks of divider outputs and for measuring external reference signals.

## Interface
- `CNT_WIDTH`, default 8: width of the internal counter and of the `period`/`high_time` outputs. Maximum measurable period is 2^CNT_WIDTH−1 cycles.

- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  measurement enable; level-sensitive.
- `sig_in`  input  1  signal to measure; may be asynchronous to `clk`.
- `period`  output  CNT_WIDTH  clk cycles from one `sig_in` rising edge to the next; holds the last valid value.
- `high_time`  output  CNT_WIDTH  clk cycles `sig_in` was high within that period; updates together with `period`.
- `meas_valid`  output  1  one-cycle pulse when `period`/`high_time` update.
- `timeout`  output  1  sticky flag: counter saturated without a rising edge.

## Operation
- Synchronizer: `sig_in` passes through a two-flop synchronizer (s1→s2), then one delay flop d. It runs regardless of `en`.
  - rise = s2 & ~d
  - fall = ~s2 & d
- FSM states: IDLE, ARM, MEAS.
  - IDLE: cnt=0. If `en`=1, go to ARM next cycle.
  - ARM: wait for the first rise. On rise: cnt<=1, go to MEAS.
  - MEAS, no edge: cnt<=cnt+1.
  - MEAS, fall: hi_lat<=cnt; cnt<=cnt+1.
  - MEAS, rise: `period`<=cnt, `high_time`<=hi_lat, `meas_valid`<=1, `timeout`<=0, cnt<=1; stay in MEAS.
  - MEAS, cnt==2^W−1 with no rise that cycle: `timeout`<=1, cnt<=0, go to ARM. `period` and `high_time` are unchanged.
  - A rise in the same cycle that cnt==2^W−1 takes priority: it is a valid measurement with `period`=2^W−1.
- `en`=0 in any state: go to IDLE next cycle, cnt<=0, `timeout`<=0.
  - A rise in that same cycle is ignored; no `meas_valid`.
  - `period` and `high_time` hold their values.
- The first rise after arming only starts the count. The first `meas_valid` requires a second rise.
- Arithmetic: cnt is unsigned CNT_WIDTH bits and never wraps, because saturation is handled by the timeout path.
- Input constraints:
  - `sig_in` synchronous to `clk`: high and low phases must each be ≥1 cycle.
  - `sig_in` asynchronous: phases must each be ≥2 cycles.
  - Shorter pulses may be missed; no requirement applies to them.

## Timing
- Reset (asynchronous assert): `period`=0, `high_time`=0, `meas_valid`=0, `timeout`=0, state IDLE, synchronizer flops 0.
- Reset mid-measurement clears everything immediately. Measurement restarts in ARM after release if `en`=1.
- Latency: `sig_in` is first sampled high at edge N. rise is true after edge N+1. `meas_valid`/`period` are visible after edge N+2.
- `meas_valid` is high for exactly one cycle per measurement. Consecutive pulses are `period` cycles apart for a steady input.
- `timeout` goes high the cycle after cnt reaches 2^W−1. It stays high until the next `meas_valid`, `en`=0, or reset.
- `en` rising: ARM is active after the next edge. A rise detected in that first ARM cycle is accepted.

## Test plan
- CNT_WIDTH=8, `sig_in` = clk/8 square wave (4 cycles high, 4 low), `en`=1 → no `meas_valid` until the second rise. Then `meas_valid` pulses every 8 cycles with `period`=8 and `high_time`=4; `timeout`=0 throughout.
- `sig_in` from a clk_div2-style toggle (1 high, 1 low) → `period`=2, `high_time`=1, `meas_valid` every 2 cycles. Then 3 high / 7 low → `period`=10, `high_time`=3.
- One rise, then `sig_in` held low → `timeout`=1 the cycle after cnt=255, no `meas_valid`. On the next two rises: first re-arms, second gives `meas_valid` and `timeout` clears.
- Input period exactly 255 (rise coincides with cnt=255) → `period`=255, `meas_valid`=1, `timeout` stays 0. Period 256 → `timeout`=1.
- `en` dropped mid-measurement for 1 cycle, then restored → no `meas_valid` for the interrupted period, `timeout`=0. `period`/`high_time` hold the old values; the next valid update needs two new rises.
- `reset_n` asserted asynchronously mid-period → all outputs 0 before the next clk edge. After release, behaviour matches the first scenario.
